// File: rtl/circular_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : circular_fifo_if
//  Description : Push/pop bus between a FIFO client (master) and the FIFO (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface circular_fifo_if #(
    parameter int WIDTH  = 8,
    parameter int CNTWID = 4
);
    logic              push;
    logic              pop;
    logic [WIDTH-1:0]  data_in;
    logic [WIDTH-1:0]  data_out;
    logic              push_acc;
    logic              pop_acc;
    logic              full;
    logic              empty;
    logic [CNTWID-1:0] count;

    modport master (
        output push, pop, data_in,
        input  data_out, push_acc, pop_acc, full, empty, count
    );

    modport slave (
        input  push, pop, data_in,
        output data_out, push_acc, pop_acc, full, empty, count
    );
endinterface
`default_nettype wire

// File: rtl/circular_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : circular_fifo
//  Description : Synchronous circular-buffer FIFO with combinational head output
//                and accepted-transfer strobes.
//  Revision    : 1.0  initial release
// ============================================================================
module circular_fifo #(
    parameter int DEPTH  = 8,
    parameter int WIDTH  = 8,
    parameter int CNTWID = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    circular_fifo_if.slave     bus
);
    localparam int                c_ptr_w    = $clog2(DEPTH);
    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(DEPTH - 1);
    localparam logic [CNTWID-1:0]  c_full_cnt = CNTWID'(DEPTH);
    localparam logic [CNTWID-1:0]  c_depth    = CNTWID'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [CNTWID-1:0]  r_count;

    logic               w_empty;
    logic               w_full;
    logic               w_push_acc;
    logic               w_pop_acc;
    logic [CNTWID-1:0]  w_ptr_dist;
    logic [CNTWID-1:0]  w_count_mod;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_full_cnt);
    // A full FIFO still takes a write when the same cycle frees a slot.
    assign w_pop_acc  = rst & bus.pop & ~w_empty;
    assign w_push_acc = rst & bus.push & (~w_full | w_pop_acc);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_acc) begin
                r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop_acc) begin
                r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push_acc, w_pop_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

    assign bus.data_out = r_mem[r_rd_ptr];
    assign bus.push_acc = w_push_acc;
    assign bus.pop_acc  = w_pop_acc;
    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.count    = r_count;

    // Pointer distance modulo DEPTH must track the occupancy counter.
    assign w_ptr_dist  = (r_wr_ptr >= r_rd_ptr)
                       ? CNTWID'(r_wr_ptr) - CNTWID'(r_rd_ptr)
                       : CNTWID'(r_wr_ptr) + c_depth - CNTWID'(r_rd_ptr);
    assign w_count_mod = (r_count == c_depth) ? '0 : r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            assert (r_count <= c_full_cnt);
            assert (!(w_full && w_empty));
            assert (w_ptr_dist == w_count_mod);
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_circular_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_circular_fifo
//  Description : Directed bench for DEPTH=8 and DEPTH=5 FIFOs sharing one stimulus,
//                checked every cycle against queue models plus literal expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_circular_fifo;
    logic       clk = 1'b0;
    logic       t_rst = 1'b0;
    logic       t_push = 1'b0;
    logic       t_pop = 1'b0;
    logic [7:0] t_din = 8'h00;

    int vectors = 0;
    int miscompares = 0;
    bit check_en = 1'b0;

    logic [7:0] q8 [$];
    logic [7:0] q5 [$];

    always #5 clk = ~clk;

    circular_fifo_if #(.WIDTH(8), .CNTWID(4)) if8 ();
    circular_fifo_if #(.WIDTH(8), .CNTWID(4)) if5 ();

    assign if8.push = t_push;  assign if8.pop = t_pop;  assign if8.data_in = t_din;
    assign if5.push = t_push;  assign if5.pop = t_pop;  assign if5.data_in = t_din;

    circular_fifo #(.DEPTH(8), .WIDTH(8), .CNTWID(4)) u_fifo8 (.clk(clk), .rst(t_rst), .bus(if8));
    circular_fifo #(.DEPTH(5), .WIDTH(8), .CNTWID(4)) u_fifo5 (.clk(clk), .rst(t_rst), .bus(if5));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_dut(input string tag, input int depth, input int size,
                             input logic [7:0] head, input logic [3:0] cnt,
                             input logic e, input logic f, input logic pa,
                             input logic ps, input logic [7:0] dout);
        logic exp_pa;
        logic exp_ps;
        exp_pa = t_rst && t_pop && (size > 0);
        exp_ps = t_rst && t_push && ((size < depth) || exp_pa);
        check({tag, ".count"},    32'(cnt), 32'(size));
        check({tag, ".empty"},    32'(e),   32'(size == 0));
        check({tag, ".full"},     32'(f),   32'(size == depth));
        check({tag, ".pop_acc"},  32'(pa),  32'(exp_pa));
        check({tag, ".push_acc"}, 32'(ps),  32'(exp_ps));
        if (size > 0) check({tag, ".data_out"}, 32'(dout), 32'(head));
    endtask

    // Reference queues advance on each edge from the inputs seen at that edge.
    always @(posedge clk) begin
        logic pa8, ps8, pa5, ps5;
        if (!t_rst) begin
            q8.delete();
            q5.delete();
        end else begin
            pa8 = t_pop && (q8.size() > 0);
            ps8 = t_push && ((q8.size() < 8) || pa8);
            pa5 = t_pop && (q5.size() > 0);
            ps5 = t_push && ((q5.size() < 5) || pa5);
            if (pa8) void'(q8.pop_front());
            if (ps8) q8.push_back(t_din);
            if (pa5) void'(q5.pop_front());
            if (ps5) q5.push_back(t_din);
        end
        check_en = 1'b1;
    end

    always @(negedge clk) begin
        if (check_en) begin
            check_dut("d8", 8, q8.size(), (q8.size() > 0) ? q8[0] : 8'h00,
                      if8.count, if8.empty, if8.full, if8.pop_acc, if8.push_acc, if8.data_out);
            check_dut("d5", 5, q5.size(), (q5.size() > 0) ? q5[0] : 8'h00,
                      if5.count, if5.empty, if5.full, if5.pop_acc, if5.push_acc, if5.data_out);
        end
    end

    task automatic step(input logic r, input logic p, input logic po, input logic [7:0] d);
        @(posedge clk);
        #1;
        t_rst = r; t_push = p; t_pop = po; t_din = d;
        @(negedge clk);
    endtask

    initial begin
        // Reset, with a push that must be ignored, then idle.
        step(1'b0, 1'b1, 1'b0, 8'hEE);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (3) step(1'b1, 1'b0, 1'b0, 8'h00);
        check("lit_rst_count", 32'(if8.count), 32'd0);
        check("lit_rst_empty", 32'(if8.empty), 32'd1);
        check("lit_rst_full", 32'(if8.full), 32'd0);
        check("lit_rst_push_acc", 32'(if8.push_acc), 32'd0);
        check("lit_rst_pop_acc", 32'(if8.pop_acc), 32'd0);

        // Basic FIFO ordering.
        step(1'b1, 1'b1, 1'b0, 8'h11);
        step(1'b1, 1'b1, 1'b0, 8'h22);
        step(1'b1, 1'b1, 1'b0, 8'h33);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        check("lit_pop1_data", 32'(if8.data_out), 32'h11);
        check("lit_pop1_acc", 32'(if8.pop_acc), 32'd1);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        check("lit_pop2_data", 32'(if8.data_out), 32'h22);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        check("lit_pop3_data", 32'(if8.data_out), 32'h33);
        check("lit_pop3_acc", 32'(if8.pop_acc), 32'd1);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check("lit_drained_empty", 32'(if8.empty), 32'd1);

        // Fill, refused push while full, then push+pop while full.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h01 + i));
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check("lit_full_flag", 32'(if8.full), 32'd1);
        check("lit_full_count", 32'(if8.count), 32'd8);
        check("lit_full_count_d5", 32'(if5.count), 32'd5);
        step(1'b1, 1'b1, 1'b0, 8'hAA);
        check("lit_full_push_refused", 32'(if8.push_acc), 32'd0);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check("lit_full_count_held", 32'(if8.count), 32'd8);
        step(1'b1, 1'b1, 1'b1, 8'hAA);
        check("lit_full_pp_push_acc", 32'(if8.push_acc), 32'd1);
        check("lit_full_pp_pop_acc", 32'(if8.pop_acc), 32'd1);
        check("lit_full_pp_data", 32'(if8.data_out), 32'h01);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check("lit_full_pp_count", 32'(if8.count), 32'd8);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 1'b1, 8'h00);
            if (i == 7) check("lit_aa_exits_last", 32'(if8.data_out), 32'hAA);
        end

        // Push+pop on an empty FIFO: no bypass.
        step(1'b1, 1'b1, 1'b1, 8'h5C);
        check("lit_empty_pp_push_acc", 32'(if8.push_acc), 32'd1);
        check("lit_empty_pp_pop_acc", 32'(if8.pop_acc), 32'd0);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check("lit_empty_pp_count", 32'(if8.count), 32'd1);
        check("lit_empty_pp_data", 32'(if8.data_out), 32'h5C);
        step(1'b1, 1'b0, 1'b1, 8'h00);

        // Twelve push/pop pairs walk the pointers around both depths.
        step(1'b1, 1'b1, 1'b0, 8'h40);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b1, 1'b1, 8'(8'h41 + i));
            check("lit_pair_d5_data", 32'(if5.data_out), 32'(8'h40 + i));
            check("lit_pair_d8_data", 32'(if8.data_out), 32'(8'h40 + i));
        end
        step(1'b1, 1'b0, 1'b1, 8'h00);
        check("lit_pair_tail", 32'(if5.data_out), 32'h4C);

        // Mid-operation reset with a push that must be discarded.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 8'(8'h71 + i));
        step(1'b0, 1'b1, 1'b0, 8'h99);
        check("lit_rst_push_ignored", 32'(if8.push_acc), 32'd0);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check("lit_midrst_count", 32'(if8.count), 32'd0);
        check("lit_midrst_empty", 32'(if8.empty), 32'd1);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        check("lit_midrst_pop_refused", 32'(if8.pop_acc), 32'd0);
        step(1'b1, 1'b1, 1'b0, 8'h12);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        check("lit_after_rst_count", 32'(if8.count), 32'd1);
        check("lit_after_rst_data", 32'(if8.data_out), 32'h12);
        step(1'b1, 1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
